// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_assembler
//  Purpose  : Packs NUM_BYTES consecutive UART bytes into one command word
//             (first byte in the MSBs) and hands it to the command processor
//             through a cmd_rdy / clr_cmd_rdy handshake. An inter-byte timeout
//             throws away partial frames so one lost byte cannot shift every
//             later command out of alignment.
//  Ports    :
//    clk          in   system clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    rx_rdy       in   receiver holds a valid byte
//    rx_data      in   [7:0] byte from the receiver
//    clr_rdy      out  byte-consumed acknowledge (mirrors rx_rdy)
//    cmd          out  [8*NUM_BYTES-1:0] assembled command, byte 0 in MSBs
//    cmd_rdy      out  cmd holds a complete, unconsumed command
//    clr_cmd_rdy  in   consumer acknowledges cmd
//    busy         out  partial frame in progress
//    overrun      out  sticky: command completed while previous unconsumed
//    frame_err    out  one-cycle pulse when a partial frame times out
//  Revision : 1.0  initial release
// ============================================================================
module uart_cmd_assembler #(
  parameter int NUM_BYTES = 3,
  parameter int TIMEOUT   = 50000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   busy,
  output logic                   overrun,
  output logic                   frame_err
);

  localparam int CMD_W  = 8 * NUM_BYTES;
  localparam int PART_W = CMD_W - 8;
  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam int BCNT_W = $clog2(NUM_BYTES);

  localparam logic [TCNT_W-1:0] C_TCNT_MAX  = TCNT_W'(TIMEOUT - 1);
  localparam logic [BCNT_W-1:0] C_LAST_BYTE = BCNT_W'(NUM_BYTES - 1);
  localparam logic [BCNT_W-1:0] C_BCNT_ONE  = BCNT_W'(1);
  localparam logic [TCNT_W-1:0] C_TCNT_ONE  = TCNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic [BCNT_W-1:0]   r_byte_cnt,   w_byte_cnt_nxt;
  logic [TCNT_W-1:0]   r_tcnt,       w_tcnt_nxt;
  logic [PART_W-1:0]   r_partial,    w_partial_nxt;
  logic [CMD_W-1:0]    r_cmd,        w_cmd_nxt;
  logic                r_cmd_rdy,    w_cmd_rdy_nxt;
  logic                r_overrun,    w_overrun_nxt;
  logic                w_complete;
  logic                w_timeout;
  logic                w_ovr_evt;

  // The block never back-pressures the receiver: every offered byte is
  // consumed on the edge it is seen.
  assign clr_rdy   = rx_rdy;
  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign overrun   = r_overrun;
  assign busy      = (r_state == ST_COLLECT);
  // Combinational so that a byte arriving in the final allowed cycle
  // suppresses the error in that same cycle.
  assign frame_err = w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
      r_tcnt     <= '0;
      r_partial  <= '0;
      r_cmd      <= '0;
      r_cmd_rdy  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_partial  <= w_partial_nxt;
      r_cmd      <= w_cmd_nxt;
      r_cmd_rdy  <= w_cmd_rdy_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_tcnt_nxt     = r_tcnt;
    w_partial_nxt  = r_partial;
    w_cmd_nxt      = r_cmd;
    w_complete     = 1'b0;
    w_timeout      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tcnt_nxt = '0;
        if (rx_rdy) begin
          // First byte of a frame: start the partial word fresh so stale
          // bytes from an abandoned frame can never leak through.
          w_partial_nxt  = PART_W'(rx_data);
          w_byte_cnt_nxt = C_BCNT_ONE;
          w_state_nxt    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (rx_rdy) begin
          w_tcnt_nxt = '0;
          if (r_byte_cnt == C_LAST_BYTE) begin
            w_complete     = 1'b1;
            w_cmd_nxt      = {r_partial, rx_data};
            w_byte_cnt_nxt = '0;
            w_state_nxt    = ST_IDLE;
          end else begin
            // Oldest byte drifts toward the MSBs; truncation drops nothing
            // because the register only ever holds NUM_BYTES-1 bytes.
            w_partial_nxt  = PART_W'({r_partial, rx_data});
            w_byte_cnt_nxt = r_byte_cnt + C_BCNT_ONE;
          end
        end else if (r_tcnt == C_TCNT_MAX) begin
          w_timeout      = 1'b1;
          w_tcnt_nxt     = '0;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_tcnt_nxt = r_tcnt + C_TCNT_ONE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_byte_cnt_nxt = '0;
        w_tcnt_nxt     = '0;
      end
    endcase
  end

  // A completion takes priority over an acknowledge in the same cycle, and
  // that acknowledge also means the consumer saw the previous word, so it is
  // not an overrun.
  assign w_ovr_evt = w_complete & r_cmd_rdy & ~clr_cmd_rdy;

  always_comb begin
    w_cmd_rdy_nxt = r_cmd_rdy;
    w_overrun_nxt = r_overrun;
    if (w_complete) begin
      w_cmd_rdy_nxt = 1'b1;
    end else if (clr_cmd_rdy) begin
      w_cmd_rdy_nxt = 1'b0;
    end
    if (w_ovr_evt) begin
      w_overrun_nxt = 1'b1;
    end else if (clr_cmd_rdy) begin
      w_overrun_nxt = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_assembler
//  Purpose  : Self-checking bench for uart_cmd_assembler (NUM_BYTES=3,
//             TIMEOUT=100). A byte-queue reference model predicts every
//             completed command into a scoreboard queue; an independent
//             monitor pops and compares whenever the DUT presents a new cmd.
//             Status outputs are compared every cycle against the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_assembler;

  localparam int NB = 3;
  localparam int TO = 100;
  localparam int CW = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          clr_cmd_rdy = 1'b0;
  logic          clr_rdy;
  logic [CW-1:0] cmd;
  logic          cmd_rdy;
  logic          busy;
  logic          overrun;
  logic          frame_err;

  always #5 clk = ~clk;

  uart_cmd_assembler #(
    .NUM_BYTES (NB),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rdy     (clr_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .busy        (busy),
    .overrun     (overrun),
    .frame_err   (frame_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]    frame[$];     // bytes of the frame in progress
  int            gap = 0;      // idle clocks since the last accepted byte
  bit            pend = 1'b0;  // expected cmd_rdy
  bit            ovr = 1'b0;   // expected overrun
  logic [CW-1:0] m_cmd = '0;   // expected cmd
  logic [CW-1:0] sb[$];        // scoreboard of completed commands

  task automatic model_reset();
    frame.delete();
    gap   = 0;
    pend  = 1'b0;
    ovr   = 1'b0;
    m_cmd = '0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic clr);
    bit            done;
    logic [CW-1:0] word;
    done = 1'b0;
    word = '0;
    if (v) begin
      frame.push_back(d);
      gap = 0;
      if (frame.size() == NB) begin
        foreach (frame[i]) word = (word << 8) | CW'(frame[i]);
        frame.delete();
        done = 1'b1;
      end
    end else if (frame.size() > 0) begin
      if (gap == TO - 1) begin
        frame.delete();
        gap = 0;
      end else begin
        gap++;
      end
    end
    if (done) begin
      if (pend && !clr) ovr = 1'b1;
      else if (clr)     ovr = 1'b0;
      pend  = 1'b1;
      m_cmd = word;
      sb.push_back(word);
    end else if (clr) begin
      pend = 1'b0;
      ovr  = 1'b0;
    end
  endtask

  // One clock of stimulus: drive at the falling edge, check settled outputs,
  // then advance the model across the coming rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic clr);
    bit exp_fe;
    @(negedge clk);
    rx_rdy      = v;
    rx_data     = d;
    clr_cmd_rdy = clr;
    #2;
    exp_fe = (frame.size() > 0) && !v && (gap == TO - 1);
    chk("clr_rdy",   32'(clr_rdy),   32'(v));
    chk("frame_err", 32'(frame_err), 32'(exp_fe));
    chk("busy",      32'(busy),      32'(frame.size() > 0));
    chk("cmd_rdy",   32'(cmd_rdy),   32'(pend));
    chk("overrun",   32'(overrun),   32'(ovr));
    chk("cmd",       32'(cmd),       32'(m_cmd));
    model_edge(v, d, clr);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd"},       32'(cmd),       32'h0);
    chk({tag, "_cmd_rdy"},   32'(cmd_rdy),   32'h0);
    chk({tag, "_overrun"},   32'(overrun),   32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_clr_rdy"},   32'(clr_rdy),   32'h0);
  endtask

  // Reset asserted between clock edges, partway through a frame.
  task automatic reset_mid();
    @(negedge clk);
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    #2;
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  logic          prev_rdy = 1'b0;
  logic [CW-1:0] prev_cmd = '0;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_rdy = 1'b0;
      prev_cmd = '0;
    end else begin
      if (cmd_rdy && (!prev_rdy || cmd !== prev_cmd)) begin
        if (sb.size() == 0) begin
          chk("cmd_unexpected", 32'(cmd_rdy), 32'h0);
        end else begin
          chk("cmd_sb", 32'(cmd), 32'(sb.pop_front()));
        end
      end
      prev_rdy = cmd_rdy;
      prev_cmd = cmd;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #2;
    chk_reset_outputs("rst_init");
    rst_n = 1'b1;

    // basic frame, bytes spaced 20 clocks apart
    send(8'hA5); idle(19); send(8'h12); idle(19); send(8'h34); idle(3);

    // handshake, then a back-to-back frame
    step(1'b0, 8'h00, 1'b1); idle(2);
    send(8'h01); send(8'h02); send(8'h03); idle(2);

    // timeout discards 0x55 0x66
    step(1'b0, 8'h00, 1'b1);
    send(8'h55); send(8'h66); idle(TO + 5);
    send(8'h77); send(8'h88); send(8'h99); idle(2);

    // bytes land exactly in the last allowed cycle
    step(1'b0, 8'h00, 1'b1);
    send(8'hC1); idle(TO - 1); send(8'hC2); idle(TO - 1); send(8'hC3); idle(2);

    // overrun and its clearing
    send(8'hDE); send(8'hAD); send(8'hBE); idle(2);
    step(1'b0, 8'h00, 1'b1); idle(2);
    send(8'h12); send(8'h34); send(8'h56); idle(2);
    send(8'hC0); send(8'hFF); step(1'b1, 8'hEE, 1'b1); idle(2);
    send(8'h0A); send(8'h0B); send(8'h0C); idle(2);
    send(8'h0D); send(8'h0E); step(1'b1, 8'h0F, 1'b1); idle(2);

    // reset in the middle of a frame
    send(8'h11); send(8'h22);
    reset_mid();
    send(8'h33); send(8'h44); send(8'h55); idle(2);

    // randomized traffic with occasional long gaps
    step(1'b0, 8'h00, 1'b1);
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        idle($urandom_range(TO - 3, TO + 3));
      end else begin
        step(1'($urandom_range(0, 2) == 0), 8'($urandom),
             1'($urandom_range(0, 5) == 0));
      end
    end
    idle(3);
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Sits directly downstream of the UART receiver. Consumes its byte handshake (rx_rdy/rx_data, returns clr_rdy).
- Packs NUM_BYTES consecutive bytes into one wide command word, first byte in the MSBs.
- Presents the word to the command processor with a cmd_rdy/clr_cmd_rdy handshake.
- An inter-byte timeout discards partial frames so a dropped byte cannot permanently misalign later commands.

Parameters:
- NUM_BYTES, 3, bytes per command (legal 2..4); cmd width = 8*NUM_BYTES.
- TIMEOUT, 50000, max clk cycles allowed between bytes of one frame (legal >= 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_rdy  input  1  receiver holds a valid byte.
- rx_data  input  8  byte from the receiver, valid while rx_rdy=1.
- clr_rdy  output  1  byte-consumed acknowledge back to the receiver.
- cmd  output  8*NUM_BYTES  assembled command; byte 0 in [8*NUM_BYTES-1 -: 8].
- cmd_rdy  output  1  cmd holds a complete, unconsumed command.
- clr_cmd_rdy  input  1  consumer acknowledges cmd.
- busy  output  1  partial frame in progress (byte_cnt != 0).
- overrun  output  1  sticky: a command completed while the previous one was still unconsumed.
- frame_err  output  1  one-cycle pulse when a partial frame is discarded by timeout.

Behaviour:
- Reset values (async, rst_n=0): cmd=0, cmd_rdy=0, overrun=0, frame_err=0, byte_cnt=0, timeout counter=0, state IDLE.
- Reset mid-frame discards all partial data. No output glitches high during reset.
- clr_rdy is combinational and equals rx_rdy. The block always accepts a byte the cycle it is offered, so it never stalls the receiver.
- Byte capture happens on a clk edge with rx_rdy=1.
  - byte_cnt < NUM_BYTES-1: shift rx_data into the partial register (MSB-first byte order), byte_cnt++, clear the timeout counter.
  - byte_cnt == NUM_BYTES-1: cmd <= {partial, rx_data}, cmd_rdy <= 1, byte_cnt <= 0. Latency is 1 clk from the last byte to cmd_rdy=1.
- State machine, two states:
  - IDLE (byte_cnt=0): busy=0. On a byte, go to COLLECT, or stay in IDLE with a completed command when NUM_BYTES would be 1 (not legal).
  - COLLECT (byte_cnt>0): busy=1. The timeout counter increments each cycle with no byte.
  - Timeout: when the counter reaches TIMEOUT-1 with no byte that cycle, go to IDLE, byte_cnt=0, pulse frame_err for exactly 1 cycle. cmd and cmd_rdy are unchanged.
- Timeout counter width is clog2(TIMEOUT). It never wraps; it is held at 0 in IDLE.
- Byte arriving on the same cycle the timeout would fire: the byte wins. It is captured, the counter clears, no frame_err.
- cmd_rdy is cleared the cycle after clr_cmd_rdy=1. cmd holds its value until the next completion.
- Completion while cmd_rdy=1 and clr_cmd_rdy=0:
  - cmd is overwritten with the new command and cmd_rdy stays 1.
  - overrun <= 1 (sticky).
- Completion on the same cycle as clr_cmd_rdy=1: set wins, so cmd_rdy=1 with the new cmd, and no overrun.
- overrun is cleared only by reset or by clr_cmd_rdy=1 on a cycle with no simultaneous overrun event.
- clr_cmd_rdy while cmd_rdy=0 has no effect.

Test Plan (NUM_BYTES=3, TIMEOUT=100):
- Basic frame: bytes 0xA5, 0x12, 0x34, each a 1-cycle rx_rdy, 20 cycles apart -> clr_rdy mirrors each rx_rdy; busy=1 after the first byte; cmd=0xA51234 and cmd_rdy=1 one cycle after 0x34; busy=0.
- Handshake: pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd still 0xA51234. Then send 0x01, 0x02, 0x03 back-to-back (3 consecutive rx_rdy cycles) -> cmd=0x010203, cmd_rdy=1, overrun=0.
- Timeout: send 0x55, 0x66, then idle 100 cycles -> frame_err pulses exactly once, on cycle 99 after 0x66, and busy=0. Then 0x77, 0x88, 0x99 -> cmd=0x778899 (no stale bytes).
- Timeout race: a byte arriving exactly on cycle TIMEOUT-1 after the previous one -> byte accepted, no frame_err, frame completes correctly.
- Overrun: with cmd_rdy=1 unacknowledged, send 0xDE, 0xAD, 0xBE -> cmd=0xDEADBE, cmd_rdy=1, overrun=1. Then clr_cmd_rdy -> overrun=0 and cmd_rdy=0. Repeat with clr_cmd_rdy coinciding with the final byte -> cmd_rdy=1, overrun=0.
- Reset mid-frame: send 0x11, 0x22, assert rst_n=0 asynchronously between clk edges, release, then send 0x33, 0x44, 0x55 -> all outputs 0 during reset; cmd=0x334455 after.
